// File: rtl/posit_mac_driver.sv
// rtl/posit_mac_driver.sv - load buffer and burst sequencer feeding the posit MAC
//
// Collects K weight/activation pairs on the load port, replays them to the MAC
// as one unbroken K-cycle valid burst, waits for the MAC result strobe (or a
// timeout), presents the result on the result port, then inserts one quiet
// cycle so the MAC accumulator clears before the next fill.
//
// Ports:
//   clk_i, rstn            clock (rising edge), asynchronous active-low reset
//   ld_vld/ld_rdy          load handshake, ld_w/ld_d weight/activation posits
//   mac_vld/mac_win/mac_din  burst to the MAC
//   mac_acc/mac_vld_o      MAC result posit and its one-cycle strobe
//   res_vld/res_rdy        result handshake, res_data posit, res_err timeout flag
//   busy                   high whenever the block is not filling
module posit_mac_driver #(
    parameter int WIDTH   = 8,
    parameter int K       = 9,
    parameter int TIMEOUT = 31
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             ld_vld,
    output logic             ld_rdy,
    input  logic [WIDTH-1:0] ld_w,
    input  logic [WIDTH-1:0] ld_d,
    output logic             mac_vld,
    output logic [WIDTH-1:0] mac_win,
    output logic [WIDTH-1:0] mac_din,
    input  logic [WIDTH-1:0] mac_acc,
    input  logic             mac_vld_o,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam int IDX_W = $clog2(K);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(K - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] NAR          = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] ST_FILL   = 3'd0;
    localparam logic [2:0] ST_SEND   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RESULT = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [IDX_W-1:0] wr_idx_q,   wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             ld_rdy_q,   ld_rdy_d;
    logic             mac_vld_q,  mac_vld_d;
    logic [WIDTH-1:0] mac_win_q,  mac_win_d;
    logic [WIDTH-1:0] mac_din_q,  mac_din_d;
    logic             res_vld_q,  res_vld_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q,  res_err_d;
    logic             busy_q,     busy_d;

    logic [WIDTH-1:0] w_buf_q [K];
    logic [WIDTH-1:0] w_buf_d [K];
    logic [WIDTH-1:0] d_buf_q [K];
    logic [WIDTH-1:0] d_buf_d [K];

    logic             ld_accept;
    logic [IDX_W-1:0] rd_nxt;

    assign ld_accept = ld_vld & ld_rdy_q;
    assign rd_nxt    = rd_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        wait_cnt_d = wait_cnt_q;
        ld_rdy_d   = ld_rdy_q;
        mac_vld_d  = mac_vld_q;
        mac_win_d  = mac_win_q;
        mac_din_d  = mac_din_q;
        res_vld_d  = res_vld_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        w_buf_d    = w_buf_q;
        d_buf_d    = d_buf_q;

        case (state_q)
            ST_FILL: begin
                if (ld_accept) begin
                    w_buf_d[wr_idx_q] = ld_w;
                    d_buf_d[wr_idx_q] = ld_d;
                    if (wr_idx_q == LAST_IDX) begin
                        // Pair 0 was written on an earlier accept (K >= 2), so
                        // it can be launched on the same edge as the last write.
                        wr_idx_d  = '0;
                        rd_idx_d  = '0;
                        state_d   = ST_SEND;
                        ld_rdy_d  = 1'b0;
                        mac_vld_d = 1'b1;
                        mac_win_d = w_buf_q[0];
                        mac_din_d = d_buf_q[0];
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // rd_idx_q is the pair currently on the MAC outputs.
                if (rd_idx_q == LAST_IDX) begin
                    state_d    = ST_WAIT;
                    rd_idx_d   = '0;
                    wait_cnt_d = '0;
                    mac_vld_d  = 1'b0;
                    mac_win_d  = '0;
                    mac_din_d  = '0;
                end else begin
                    rd_idx_d  = rd_nxt;
                    mac_win_d = w_buf_q[rd_nxt];
                    mac_din_d = d_buf_q[rd_nxt];
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A real result beats a timeout landing in the same cycle.
                if (mac_vld_o) begin
                    res_data_d = mac_acc;
                    res_err_d  = 1'b0;
                    res_vld_d  = 1'b1;
                    state_d    = ST_RESULT;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    res_data_d = NAR;
                    res_err_d  = 1'b1;
                    res_vld_d  = 1'b1;
                    state_d    = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_rdy) begin
                    res_vld_d = 1'b0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // One idle cycle so the MAC sees a break in its valid history.
                state_d  = ST_FILL;
                ld_rdy_d = 1'b1;
            end
            default: begin
                state_d  = ST_FILL;
                ld_rdy_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_FILL);
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_FILL;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            wait_cnt_q <= '0;
            ld_rdy_q   <= 1'b1;
            mac_vld_q  <= 1'b0;
            mac_win_q  <= '0;
            mac_din_q  <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            wait_cnt_q <= wait_cnt_d;
            ld_rdy_q   <= ld_rdy_d;
            mac_vld_q  <= mac_vld_d;
            mac_win_q  <= mac_win_d;
            mac_din_q  <= mac_din_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            busy_q     <= busy_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_i) begin
        w_buf_q <= w_buf_d;
        d_buf_q <= d_buf_d;
    end

    assign ld_rdy   = ld_rdy_q;
    assign mac_vld  = mac_vld_q;
    assign mac_win  = mac_win_q;
    assign mac_din  = mac_din_q;
    assign res_vld  = res_vld_q;
    assign res_data = res_data_q;
    assign res_err  = res_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_posit_mac_driver.sv
// tb/tb_posit_mac_driver.sv - directed self-checking bench for posit_mac_driver
module tb_posit_mac_driver;

    localparam int WIDTH   = 8;
    localparam int K       = 9;
    localparam int TIMEOUT = 31;

    logic             clk_i = 1'b0;
    logic             rstn;
    logic             ld_vld;
    logic             ld_rdy;
    logic [WIDTH-1:0] ld_w;
    logic [WIDTH-1:0] ld_d;
    logic             mac_vld;
    logic [WIDTH-1:0] mac_win;
    logic [WIDTH-1:0] mac_din;
    logic [WIDTH-1:0] mac_acc;
    logic             mac_vld_o;
    logic             res_vld;
    logic             res_rdy;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;

    posit_mac_driver #(.WIDTH(WIDTH), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .ld_vld    (ld_vld),
        .ld_rdy    (ld_rdy),
        .ld_w      (ld_w),
        .ld_d      (ld_d),
        .mac_vld   (mac_vld),
        .mac_win   (mac_win),
        .mac_din   (mac_din),
        .mac_acc   (mac_acc),
        .mac_vld_o (mac_vld_o),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rstn && ld_vld && ld_rdy) acc_cnt <= acc_cnt + 1;
    end

    // Loads K pairs w=wb+ws*i, d=db+ds*i; returns at the negedge right after the K-th accept.
    task automatic do_fill(input logic [7:0] wb, input logic [7:0] ws, input logic [7:0] db,
                           input logic [7:0] ds, input bit gaps, input bit hold);
        int idx = 0;
        int guard = 0;
        while (idx < K && guard < 500) begin
            @(negedge clk_i);
            guard++;
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                ld_vld = 1'b0;
            end else begin
                ld_vld = 1'b1;
                ld_w = wb + ws * 8'(idx);
                ld_d = db + ds * 8'(idx);
                if (ld_rdy) idx++;
            end
        end
        total++;
        if (idx != K) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", idx, K); end
        @(negedge clk_i);
        if (!hold) ld_vld = 1'b0;
    endtask

    // Checks the K-cycle burst; returns at the negedge of the first WAIT cycle.
    task automatic check_burst(input logic [7:0] wb, input logic [7:0] ws, input logic [7:0] db,
                               input logic [7:0] ds);
        logic [7:0] ew, ed;
        for (int i = 0; i < K; i++) begin
            ew = wb + ws * 8'(i);
            ed = db + ds * 8'(i);
            total++;
            if (mac_vld !== 1'b1 || mac_win !== ew || mac_din !== ed || ld_rdy !== 1'b0) begin
                bad++;
                $display("FAIL burst[%0d] got vld=%b w=%h d=%h rdy=%b exp vld=1 w=%h d=%h rdy=0",
                         i, mac_vld, mac_win, mac_din, ld_rdy, ew, ed);
            end
            @(negedge clk_i);
        end
        total++;
        if (mac_vld !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL burst_end got vld=%b busy=%b exp vld=0 busy=1", mac_vld, busy);
        end
    endtask

    // Strobe mac_vld_o on the lat-th WAIT cycle; returns at the negedge after it was sampled.
    task automatic mac_strobe(input int lat, input logic [7:0] acc);
        repeat (lat - 1) @(negedge clk_i);
        mac_vld_o = 1'b1;
        mac_acc   = acc;
        total++;
        if (res_vld !== 1'b0) begin bad++; $display("FAIL early_res got=%b exp=0", res_vld); end
        @(negedge clk_i);
        mac_vld_o = 1'b0;
    endtask

    task automatic check_result(input string nm, input logic [7:0] ed, input logic ee);
        total++;
        if (res_vld !== 1'b1 || res_data !== ed || res_err !== ee) begin
            bad++;
            $display("FAIL %s got vld=%b data=%h err=%b exp vld=1 data=%h err=%b",
                     nm, res_vld, res_data, res_err, ed, ee);
        end
    endtask

    // Holds res_rdy low for stall cycles, then handshakes and checks GAP timing.
    task automatic finish_result(input int stall, input logic [7:0] ed, input logic ee);
        for (int i = 0; i < stall; i++) begin
            total++;
            if (res_vld !== 1'b1 || res_data !== ed || res_err !== ee || ld_rdy !== 1'b0 || mac_vld !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d] got vld=%b data=%h err=%b rdy=%b mvld=%b exp 1 %h %b 0 0",
                         i, res_vld, res_data, res_err, ld_rdy, mac_vld, ed, ee);
            end
            @(negedge clk_i);
        end
        res_rdy = 1'b1;
        @(negedge clk_i);
        res_rdy = 1'b0;
        total++;
        if (res_vld !== 1'b0 || ld_rdy !== 1'b0 || busy !== 1'b1 || mac_vld !== 1'b0) begin
            bad++;
            $display("FAIL gap got vld=%b rdy=%b busy=%b mvld=%b exp 0 0 1 0", res_vld, ld_rdy, busy, mac_vld);
        end
        @(negedge clk_i);
        total++;
        if (ld_rdy !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL refill got rdy=%b busy=%b exp rdy=1 busy=0", ld_rdy, busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if (ld_rdy !== 1'b1 || mac_vld !== 1'b0 || mac_win !== 8'h00 || mac_din !== 8'h00 ||
            res_vld !== 1'b0 || res_data !== 8'h00 || res_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals got rdy=%b mvld=%b w=%h d=%h rvld=%b data=%h err=%b busy=%b exp 1 0 00 00 0 00 0 0",
                     ld_rdy, mac_vld, mac_win, mac_din, res_vld, res_data, res_err, busy);
        end
    endtask

    task automatic test_basic();
        do_fill(8'h40, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0);
        check_burst(8'h40, 8'h00, 8'h40, 8'h00);
        mac_strobe(16, 8'h40);
        check_result("basic_res", 8'h40, 1'b0);
        finish_result(0, 8'h40, 1'b0);
    endtask

    task automatic test_backpressure();
        int a0;
        a0 = acc_cnt;
        do_fill(8'h10, 8'h03, 8'h20, 8'h05, 1'b1, 1'b1);
        check_burst(8'h10, 8'h03, 8'h20, 8'h05);
        mac_strobe(4, 8'h11);
        ld_vld = 1'b0;
        check_result("bp_res", 8'h11, 1'b0);
        total++;
        if (acc_cnt - a0 != K) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", acc_cnt - a0, K); end
        finish_result(0, 8'h11, 1'b0);
    endtask

    task automatic test_result_stall();
        do_fill(8'h01, 8'h01, 8'h02, 8'h02, 1'b0, 1'b0);
        check_burst(8'h01, 8'h01, 8'h02, 8'h02);
        mac_strobe(2, 8'h48);
        check_result("stall_res", 8'h48, 1'b0);
        finish_result(20, 8'h48, 1'b0);
    endtask

    task automatic test_timeout();
        do_fill(8'h30, 8'h01, 8'h50, 8'h01, 1'b0, 1'b0);
        check_burst(8'h30, 8'h01, 8'h50, 8'h01);
        repeat (TIMEOUT - 1) @(negedge clk_i);
        total++;
        if (res_vld !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", res_vld); end
        @(negedge clk_i);
        check_result("timeout_res", 8'h80, 1'b1);
        finish_result(0, 8'h80, 1'b1);
    endtask

    task automatic test_simultaneous();
        do_fill(8'h70, 8'hFF, 8'h08, 8'h01, 1'b0, 1'b0);
        check_burst(8'h70, 8'hFF, 8'h08, 8'h01);
        mac_strobe(TIMEOUT, 8'h5A);
        check_result("simul_res", 8'h5A, 1'b0);
        finish_result(0, 8'h5A, 1'b0);
    endtask

    task automatic test_stray_strobe();
        @(negedge clk_i);
        mac_vld_o = 1'b1;
        mac_acc   = 8'h33;
        @(negedge clk_i);
        mac_vld_o = 1'b0;
        total++;
        if (res_vld !== 1'b0 || busy !== 1'b0 || ld_rdy !== 1'b1 || res_data === 8'h33) begin
            bad++;
            $display("FAIL stray got rvld=%b busy=%b rdy=%b data=%h exp 0 0 1 not-33", res_vld, busy, ld_rdy, res_data);
        end
        do_fill(8'h0A, 8'h02, 8'h0B, 8'h02, 1'b0, 1'b0);
        check_burst(8'h0A, 8'h02, 8'h0B, 8'h02);
        mac_strobe(3, 8'h22);
        check_result("stray_res", 8'h22, 1'b0);
        finish_result(0, 8'h22, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        do_fill(8'hA0, 8'h01, 8'hB0, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        total++;
        if (mac_vld !== 1'b1 || mac_win !== 8'hA3) begin
            bad++; $display("FAIL pre_rst got vld=%b w=%h exp vld=1 w=a3", mac_vld, mac_win);
        end
        rstn = 1'b0;
        #1;
        test_reset();
        @(negedge clk_i);
        rstn = 1'b1;
        do_fill(8'hC0, 8'h01, 8'hD0, 8'h01, 1'b0, 1'b0);
        check_burst(8'hC0, 8'h01, 8'hD0, 8'h01);
        mac_strobe(5, 8'h3C);
        check_result("post_rst_res", 8'h3C, 1'b0);
        finish_result(0, 8'h3C, 1'b0);
    endtask

    initial begin
        rstn      = 1'b0;
        ld_vld    = 1'b0;
        ld_w      = '0;
        ld_d      = '0;
        mac_acc   = '0;
        mac_vld_o = 1'b0;
        res_rdy   = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_backpressure();
        test_result_stall();
        test_timeout();
        test_simultaneous();
        test_stray_strobe();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
